mask_reg_bank: RTL and testbench
================================

MASK_REG_BANK -- requirements
Module: mask_reg_bank

Interface
REQ-001 SHALL have parameter N, default 10, mask width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of mask entries (>=1).
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- PIM_load  in  1  load D into entry wr_idx
- Mov_load  in  1  load MOV_in into entry wr_idx
- wr_idx  in  $clog2(DEPTH)  write entry select
- D  in  N  PIM load data
- MOV_in  in  N  move load data
- rd_idx  in  $clog2(DEPTH)  read entry select
- Q  out  N  registered read data
- shift_start  in  1  request shift of entry sh_idx
- sh_idx  in  $clog2(DEPTH)  shift entry select
- shift_amt  in  $clog2(N+1)  bit positions to shift
- shift_dir  in  1  0 = toward MSB, 1 = toward LSB
- busy  out  1  shift engine not idle
- done  out  1  one-cycle shift completion pulse
- aborted  out  1  qualifies done: shift cut short by a load

Function
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk, rst_n.
REQ-005 Write priority per edge: PIM_load > Mov_load > shift step > hold; both loads high writes D only.
REQ-006 Only entry wr_idx is written by a load; all other entries hold unless shifted.
REQ-007 Q SHALL equal entry[rd_idx] as sampled at the previous edge (1-cycle latency, pre-write value).
REQ-008 wr_idx, rd_idx or sh_idx >= DEPTH: write/start ignored, Q loads 0.
REQ-009 FSM states IDLE, SHIFT, DONE; busy = (state != IDLE).
REQ-010 IDLE: shift_start sampled high latches sh_idx, dir, amt; amt>0 -> SHIFT, amt=0 -> DONE.
REQ-011 shift_amt > N SHALL be clamped to N.
REQ-012 SHIFT: each edge shifts latched entry by one bit and decrements counter; last step -> DONE.
REQ-013 Latency: start at edge t0, steps at edges t1..tk, done high in cycle after tk, IDLE after tk+1.
REQ-014 DONE: done=1 for exactly one cycle, then IDLE; new start accepted in IDLE only.
REQ-015 shift_start while busy SHALL be ignored (not queued).
REQ-016 Load to the latched entry during SHIFT: load wins, shift stops, next state DONE, aborted=1 with done.
REQ-017 Load to a different entry during SHIFT SHALL proceed in parallel with the step.

Reset
REQ-018 rst_n low SHALL clear all entries, Q, busy, done, aborted, counter to 0 and FSM to IDLE, immediately.
REQ-019 Reset mid-shift SHALL abandon the operation with no done pulse.

Configuration
REQ-020 Macro MASK_ROTATE_EN defined: vacated bit takes the bit shifted out (rotate).
REQ-021 MASK_ROTATE_EN undefined: vacated bit filled with 0 (logical shift).

Structure
REQ-022 Package mask_pkg SHALL hold the FSM state enum and shift-direction constants.
REQ-023 Single-bit step SHALL be sub-module mask_shift_step (combinational, N-wide, dir input, honours MASK_ROTATE_EN).

Verification (N=10, DEPTH=4)
REQ-024 Reset then PIM_load D=10'h2A5 idx2, rd_idx=2 -> Q=10'h2A5 one cycle after write edge; other entries read 0.
REQ-025 PIM_load D=10'h00F and Mov_load MOV_in=10'h3F0 same edge idx1 -> entry1=10'h00F.
REQ-026 entry0=10'h001, start amt=3 dir=0 -> busy 4 cycles, done after 3rd step, entry0=10'h008.
REQ-027 entry0=10'h001, amt=1 dir=1 -> 10'h200 with MASK_ROTATE_EN, 10'h000 without.
REQ-028 Shift amt=5 on entry3, PIM_load entry3 10'h155 at 2nd step -> entry3=10'h155, done=aborted=1 next cycle.
REQ-029 rst_n low during SHIFT -> busy=0 at once, no done, all entries 0; start amt=0 afterwards -> done next cycle.

Source files
------------

// File: rtl/mask_pkg.sv
// Shared types for the mask register bank: shift FSM states and direction codes.
package mask_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } mask_state_e;

    localparam logic DIR_TO_MSB = 1'b0;
    localparam logic DIR_TO_LSB = 1'b1;

endpackage

// File: rtl/mask_shift_step.sv
// Single-bit shift of an N-wide mask; define MASK_ROTATE_EN to rotate
// instead of zero-filling the vacated bit.
module mask_shift_step
    import mask_pkg::*;
#(
    parameter int N = 10
) (
    input  logic [N-1:0] din,
    input  logic         dir,
    output logic [N-1:0] dout
);

    always_comb begin
        if (dir == DIR_TO_LSB) begin
            dout = din >> 1;
`ifdef MASK_ROTATE_EN
            dout[N-1] = din[0];
`else
            dout[N-1] = 1'b0;
`endif
        end else begin
            dout = din << 1;
`ifdef MASK_ROTATE_EN
            dout[0] = din[N-1];
`else
            dout[0] = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/mask_reg_bank.sv
// Bank of DEPTH N-bit mask registers with a registered read port and a
// multi-cycle shift engine; MASK_ROTATE_EN selects rotate vs logical shift.
module mask_reg_bank
    import mask_pkg::*;
#(
    parameter  int N     = 10,
    parameter  int DEPTH = 4,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int AW    = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          PIM_load,
    input  logic          Mov_load,
    input  logic [IW-1:0] wr_idx,
    input  logic [N-1:0]  D,
    input  logic [N-1:0]  MOV_in,
    input  logic [IW-1:0] rd_idx,
    output logic [N-1:0]  Q,
    input  logic          shift_start,
    input  logic [IW-1:0] sh_idx,
    input  logic [AW-1:0] shift_amt,
    input  logic          shift_dir,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    logic [N-1:0]  entry_q [DEPTH];
    logic [N-1:0]  entry_d [DEPTH];
    logic [N-1:0]  q_q, q_d;
    mask_state_e   state_q, state_d;
    logic [IW-1:0] sidx_q, sidx_d;
    logic          dir_q, dir_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;

    logic          wr_ok, rd_ok, sh_ok;
    logic          load_en;
    logic [N-1:0]  load_data;
    logic [AW-1:0] amt_clamped;
    logic [N-1:0]  step_out;

    assign wr_ok       = 32'(wr_idx) < 32'(DEPTH);
    assign rd_ok       = 32'(rd_idx) < 32'(DEPTH);
    assign sh_ok       = 32'(sh_idx) < 32'(DEPTH);
    assign load_en     = (PIM_load | Mov_load) & wr_ok;
    assign load_data   = PIM_load ? D : MOV_in;
    assign amt_clamped = (32'(shift_amt) > 32'(N)) ? AW'(N) : shift_amt;

    mask_shift_step #(.N(N)) u_step (
        .din  (entry_q[sidx_q]),
        .dir  (dir_q),
        .dout (step_out)
    );

    always_comb begin
        entry_d = entry_q;
        state_d = state_q;
        sidx_d  = sidx_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        q_d     = rd_ok ? entry_q[rd_idx] : '0;

        unique case (state_q)
            ST_IDLE: begin
                if (shift_start && sh_ok) begin
                    sidx_d  = sh_idx;
                    dir_d   = shift_dir;
                    cnt_d   = amt_clamped;
                    abort_d = 1'b0;
                    state_d = (amt_clamped == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A load hitting the entry being shifted cancels the remaining steps.
                if (load_en && (wr_idx == sidx_q)) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    entry_d[sidx_q] = step_out;
                    cnt_d           = cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (load_en) begin
            entry_d[wr_idx] = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '{default: '0};
            q_q     <= '0;
            state_q <= ST_IDLE;
            sidx_q  <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            q_q     <= q_d;
            state_q <= state_d;
            sidx_q  <= sidx_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    assign Q       = q_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign aborted = (state_q == ST_DONE) && abort_q;

endmodule

// File: tb/tb_mask_reg_bank.sv
// Directed bench for mask_reg_bank (N=10, DEPTH=4) with a cycle-level
// behavioural model; honours MASK_ROTATE_EN for expected shift results.
module tb_mask_reg_bank;

`ifdef MASK_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       PIM_load = 1'b0, Mov_load = 1'b0;
    logic [1:0] wr_idx = '0, rd_idx = '0, sh_idx = '0;
    logic [9:0] D = '0, MOV_in = '0, Q;
    logic       shift_start = 1'b0, shift_dir = 1'b0;
    logic [3:0] shift_amt = '0;
    logic       busy, done, aborted;

    mask_reg_bank #(.N(10), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .PIM_load(PIM_load), .Mov_load(Mov_load),
        .wr_idx(wr_idx), .D(D), .MOV_in(MOV_in), .rd_idx(rd_idx), .Q(Q),
        .shift_start(shift_start), .sh_idx(sh_idx), .shift_amt(shift_amt),
        .shift_dir(shift_dir), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: memory contents, registered read, and a shift schedule expressed
    // as "steps still owed" plus the cycle number in which done must show.
    int mem [4] = '{0, 0, 0, 0};
    int nm  [4];
    int q_m = 0;
    int cyc = 0;
    int steps_left = 0;
    int done_cyc = -1;
    bit ab_m = 0;
    int op_idx = 0;
    bit op_dir = 0;
    bit idle_pre, wv;
    int wd, k;

    function automatic int step_m(input int v, input bit dir);
        if (!dir) return (v * 2) % 1024 + (ROT ? v / 512 : 0);
        else      return v / 2 + (ROT ? (v % 2) * 512 : 0);
    endfunction

    always @(negedge rst_n) begin
        mem = '{0, 0, 0, 0};
        q_m = 0;
        steps_left = 0;
        done_cyc = -1;
        ab_m = 0;
    end

    always @(posedge clk) begin
        idle_pre = (steps_left == 0) && (done_cyc != cyc);
        cyc++;
        if (rst_n) begin
            q_m = mem[rd_idx];
            nm = mem;
            wv = PIM_load || Mov_load;
            wd = PIM_load ? int'(D) : int'(MOV_in);
            if (steps_left > 0) begin
                if (wv && int'(wr_idx) == op_idx) begin
                    steps_left = 0;
                    done_cyc = cyc;
                    ab_m = 1;
                end else begin
                    nm[op_idx] = step_m(mem[op_idx], op_dir);
                    steps_left--;
                    if (steps_left == 0) begin
                        done_cyc = cyc;
                        ab_m = 0;
                    end
                end
            end
            if (wv) nm[wr_idx] = wd;
            if (idle_pre && shift_start) begin
                k = (shift_amt > 10) ? 10 : int'(shift_amt);
                op_idx = int'(sh_idx);
                op_dir = shift_dir;
                ab_m = 0;
                if (k == 0) done_cyc = cyc;
                else steps_left = k;
            end
            mem = nm;
        end
    end

    always @(negedge clk) begin
        chk("q", 32'(Q), 32'(q_m));
        chk("busy", 32'(busy), 32'((steps_left > 0) || (done_cyc == cyc)));
        chk("done", 32'(done), 32'(done_cyc == cyc));
        chk("aborted", 32'(aborted), 32'((done_cyc == cyc) && ab_m));
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int idx, input int val);
        PIM_load = 1'b1;
        wr_idx = idx[1:0];
        D = val[9:0];
        tick();
        PIM_load = 1'b0;
    endtask

    task automatic read(input int idx, input int exp, input string nmx);
        rd_idx = idx[1:0];
        tick();
        chk(nmx, 32'(Q), exp);
    endtask

    task automatic run_shift(input int idx, input int amt, input bit dir, input bit poke,
                             output int busy_cycles, output bit saw_done);
        shift_start = 1'b1;
        sh_idx = idx[1:0];
        shift_amt = amt[3:0];
        shift_dir = dir;
        tick();
        shift_start = 1'b0;
        busy_cycles = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            busy_cycles++;
            if (done) saw_done = 1'b1;
            // A start request while busy must be dropped, not queued.
            if (poke && i == 1) begin
                shift_start = 1'b1;
                sh_idx = 2'd1;
                shift_amt = 4'd2;
            end else begin
                shift_start = 1'b0;
            end
            tick();
        end
        shift_start = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        bit sd;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("reset_q", 32'(Q), 0);
        chk("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;

        load(2, 'h2A5);
        read(2, 'h2A5, "pim_load_rd2");
        read(0, 0, "rd0_zero");
        read(1, 0, "rd1_zero");
        read(3, 0, "rd3_zero");

        PIM_load = 1'b1; Mov_load = 1'b1; wr_idx = 2'd1; D = 10'h00F; MOV_in = 10'h3F0;
        tick();
        PIM_load = 1'b0; Mov_load = 1'b0;
        read(1, 'h00F, "pim_over_mov");

        load(0, 'h001);
        run_shift(0, 3, 1'b0, 1'b1, bc, sd);
        chk("amt3_busy_cycles", bc, 4);
        chk("amt3_done_seen", 32'(sd), 1);
        read(0, 'h008, "amt3_result");
        read(1, 'h00F, "busy_start_ignored");

        load(0, 'h001);
        run_shift(0, 1, 1'b1, 1'b0, bc, sd);
        chk("lsb_busy_cycles", bc, 2);
        read(0, ROT ? 'h200 : 'h000, "lsb_shift_fill");

        load(1, 'h001);
        run_shift(1, 15, 1'b0, 1'b0, bc, sd);
        chk("clamp_busy_cycles", bc, 11);
        read(1, ROT ? 'h001 : 'h000, "clamp_result");

        load(3, 'h003);
        rd_idx = 2'd3;
        shift_start = 1'b1; sh_idx = 2'd3; shift_amt = 4'd5; shift_dir = 1'b0;
        tick();
        shift_start = 1'b0;
        Mov_load = 1'b1; wr_idx = 2'd2; MOV_in = 10'h0AA;
        tick();
        Mov_load = 1'b0;
        PIM_load = 1'b1; wr_idx = 2'd3; D = 10'h155;
        tick();
        PIM_load = 1'b0;
        chk("abort_done", 32'(done), 1);
        chk("abort_flag", 32'(aborted), 1);
        tick();
        chk("abort_idle", 32'(busy), 0);
        read(3, 'h155, "abort_load_wins");
        read(2, 'h0AA, "parallel_load");

        shift_start = 1'b1; sh_idx = 2'd0; shift_amt = 4'd5; shift_dir = 1'b0;
        tick();
        shift_start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy_now", 32'(busy), 0);
        chk("rst_done_now", 32'(done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        shift_start = 1'b1; sh_idx = 2'd1; shift_amt = 4'd0;
        tick();
        shift_start = 1'b0;
        chk("amt0_done", 32'(done), 1);
        chk("amt0_not_aborted", 32'(aborted), 0);
        tick();
        chk("amt0_idle", 32'(busy), 0);
        read(2, 0, "rst_cleared2");
        read(3, 0, "rst_cleared3");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
